// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared constants and types for the RV32M multiply/divide unit
package muldiv_unit_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default datapath width; one iteration per operand bit
    localparam int DEF_BIT_W = 32;

    // Width of the iteration counter needed to count BIT_W iterations
    function automatic int iter_cnt_w(input int bit_w);
        return (bit_w > 1) ? $clog2(bit_w) : 1;
    endfunction

    // EX-stage writeback mux: ALU output versus this unit's result
    localparam logic EX_SEL_ALU    = 1'b0;
    localparam logic EX_SEL_MULDIV = 1'b1;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with fixed latency
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int BIT_W = DEF_BIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [2:0]       i_funct3,
    input  logic [BIT_W-1:0] i_a,
    input  logic [BIT_W-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic [BIT_W-1:0] o_result
);

    localparam int                 CNT_W     = iter_cnt_w(BIT_W);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(BIT_W - 1);
    localparam logic [BIT_W-1:0]   INT_MIN   = {1'b1, {(BIT_W-1){1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op;
    logic [BIT_W-1:0]   a_mag;
    logic [BIT_W-1:0]   b_mag;
    logic [BIT_W-1:0]   a_raw;
    logic               b_zero;
    logic               sgn_ovf;
    logic               neg_hi;
    logic               neg_rem;
    // acc: upper product word (multiply) or BIT_W+1-bit partial remainder (divide)
    // lo:  multiplier shifting out LSB first, or dividend/quotient shifting MSB first
    logic [BIT_W:0]     acc;
    logic [BIT_W-1:0]   lo;

    logic               accept;
    logic               a_signed;
    logic               b_signed;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [BIT_W-1:0]   a_mag_in;
    logic [BIT_W-1:0]   b_mag_in;

    logic [BIT_W:0]     mul_add;
    logic [BIT_W:0]     mul_sum;
    logic [BIT_W:0]     div_shift;
    logic [BIT_W:0]     div_diff;
    logic               div_ge;

    logic [2*BIT_W-1:0] prod_raw;
    logic [2*BIT_W-1:0] prod_fix;
    logic [BIT_W-1:0]   quo_fix;
    logic [BIT_W-1:0]   rem_fix;
    logic [BIT_W-1:0]   fix_result;

    // Operand signedness and magnitude conversion at the accepting edge
    always_comb begin
        accept   = (state == ST_IDLE) && i_valid;
        a_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                   (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        b_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                   (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        a_neg_in = a_signed && i_a[BIT_W-1];
        b_neg_in = b_signed && i_b[BIT_W-1];
        a_mag_in = a_neg_in ? (~i_a + 1'b1) : i_a;
        b_mag_in = b_neg_in ? (~i_b + 1'b1) : i_b;
    end

    // One shift-add or restoring-divide step, all on BIT_W+1 bits
    always_comb begin
        mul_add   = lo[0] ? {1'b0, a_mag} : '0;
        mul_sum   = {1'b0, acc[BIT_W-1:0]} + mul_add;
        div_shift = {acc[BIT_W-1:0], lo[BIT_W-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = ~div_diff[BIT_W];
    end

    // Sign restoration and special-case selection for the final word
    always_comb begin
        prod_raw = {acc[BIT_W-1:0], lo};
        prod_fix = neg_hi ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = neg_hi ? (~lo + 1'b1) : lo;
        rem_fix  = neg_rem ? (~acc[BIT_W-1:0] + 1'b1) : acc[BIT_W-1:0];
        fix_result = '0;
        case (op)
            F3_MUL:                      fix_result = prod_fix[BIT_W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*BIT_W-1:BIT_W];
            F3_DIV: begin
                if (b_zero)       fix_result = '1;
                else if (sgn_ovf) fix_result = a_raw;
                else              fix_result = quo_fix;
            end
            F3_DIVU:              fix_result = b_zero ? '1 : lo;
            F3_REM: begin
                if (b_zero)       fix_result = a_raw;
                else if (sgn_ovf) fix_result = '0;
                else              fix_result = rem_fix;
            end
            F3_REMU:              fix_result = b_zero ? a_raw : acc[BIT_W-1:0];
            default:              fix_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> CALC (BIT_W cycles) -> FIX -> DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_ready = (state == ST_IDLE);
        o_done  = (state == ST_DONE);
    end

    // Operand capture and iterative datapath; operands only sampled in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op      <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            a_raw   <= '0;
            b_zero  <= 1'b0;
            sgn_ovf <= 1'b0;
            neg_hi  <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            lo      <= '0;
        end else if (accept) begin
            cnt     <= '0;
            op      <= i_funct3;
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            a_raw   <= i_a;
            b_zero  <= (i_b == '0);
            sgn_ovf <= (i_a == INT_MIN) && (&i_b);
            neg_hi  <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
            acc     <= '0;
            lo      <= i_funct3[2] ? a_mag_in : b_mag_in;
        end else if (state == ST_CALC) begin
            cnt <= cnt + CNT_W'(1);
            if (op[2]) begin
                acc <= div_ge ? div_diff : div_shift;
                lo  <= {lo[BIT_W-2:0], div_ge};
            end else begin
                acc <= {1'b0, mul_sum[BIT_W:1]};
                lo  <= {mul_sum[0], lo[BIT_W-1:1]};
            end
        end
    end

    // Result register loads on entry to DONE and holds until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 o_result <= '0;
        else if (state == ST_FIX)   o_result <= fix_result;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;   // edges from accept (inclusive) to the edge raising o_done
    localparam int THR = W + 3;   // edges between back-to-back accepts

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [2:0]   i_funct3 = 3'd0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_ready;
    logic         o_done;
    logic [W-1:0] o_result;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ready_hi = 0;
    int   last_acc = 0;

    muldiv_unit #(.BIT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_funct3 (i_funct3),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every o_done and checks result and timing
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && o_ready) ready_hi++;
        if (o_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_done=1 result %h expected no done", o_result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_%0d", e.tag), o_result, e.res);
                check($sformatf("latency_%0d", e.tag), W'(cyc - e.acc + 1), W'(LAT));
                check($sformatf("ready_busy_%0d", e.tag), W'(ready_hi), W'(0));
            end
            ready_hi = 0;
        end
    end

    // Issue one op; optionally keep i_valid high with scrambled operands while busy
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input int tag, input int hold);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_%0d: got o_ready=0 expected 1", tag);
        end
        i_funct3 = op;
        i_a      = a;
        i_b      = b;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{res, cyc, tag});
        last_acc = cyc;
        for (int k = 0; k < hold; k++) begin
            i_a = $urandom;
            i_b = $urandom;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    initial begin
        int acc1;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", W'(o_ready), W'(1));
        check("rst_done", W'(o_done), W'(0));
        check("rst_result", o_result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
        issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);
        issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 0);
        issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0);
        issue(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5, 0);
        issue(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 6, 0);
        issue(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 7, 0);
        issue(F3_DIVU,   32'd100,       32'd7,         32'd14,        8, 0);
        issue(F3_REMU,   32'd100,       32'd7,         32'd2,         9, 0);
        issue(F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 10, 0);
        issue(F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         11, 0);
        issue(F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 12, 0);
        issue(F3_REMU,   32'h1234,      32'd0,         32'h1234,      13, 0);
        issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 14, 0);
        issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 15, 0);

        // i_valid held high with changing operands while busy
        issue(F3_MUL,    32'd6,         32'd7,         32'd42,        16, 12);

        // Back-to-back: second accept in the first IDLE cycle after DONE
        issue(F3_DIVU,   32'd1000,      32'd10,        32'd100,       17, 0);
        acc1 = last_acc;
        issue(F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 18, 0);
        check("throughput", W'(last_acc - acc1), W'(THR));

        // Reset in the middle of CALC aborts the op
        issue(F3_DIV,    32'd1000,      32'd3,         32'd333,       19, 0);
        repeat (10) @(posedge clk);
        #2;
        check("busy_before_abort", W'(o_ready), W'(0));
        rst_n = 1'b0;
        #1;
        check("abort_ready", W'(o_ready), W'(1));
        check("abort_done", W'(o_done), W'(0));
        check("abort_result", o_result, '0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        issue(F3_MUL,    32'd3,         32'd4,         32'd12,        20, 0);

        // Drain the scoreboard with a bound
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", W'(sb.size()), W'(0));
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; sits beside the single-cycle ALU in the EX stage and covers the operations the ALU does not.
- The EX stage presents operands and funct3 with a valid/ready handshake. The unit computes over a fixed number of cycles and returns the result with a one-cycle done pulse.
- The pipeline control stalls EX while the unit is busy.

Parameters:
- BIT_W, 32, operand/result width; also the iteration count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  request; an operation is accepted on a rising edge where i_valid && o_ready.
- i_funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_a  input  BIT_W  rs1 operand (multiplicand/dividend).
- i_b  input  BIT_W  rs2 operand (multiplier/divisor).
- o_ready  output  1  high only in IDLE.
- o_done  output  1  one-cycle pulse; o_result is valid in this cycle.
- o_result  output  BIT_W  result; held until the next accept.

Behaviour:
- Reset (async, rst_n low): state IDLE, o_ready 1, o_done 0, o_result 0, all internal registers cleared. Reset asserted mid-operation aborts the operation; no o_done follows.
- States:
  - IDLE: o_ready=1. On accept, latch operands and funct3, then go to CALC with counter=0.
  - CALC: o_ready=0; one iteration per cycle; counter increments. After BIT_W iterations (counter==BIT_W-1 at the edge), go to FIX.
  - FIX: apply sign correction and select the result word; go to DONE.
  - DONE: o_done=1 and o_result updated for exactly this cycle; o_ready=0; go to IDLE.
- Latency is fixed for every op, including special cases: o_done goes high BIT_W+2 edges after the accepting edge. Back-to-back throughput is one op per BIT_W+3 cycles; a new accept can occur in the first IDLE cycle after DONE.
- i_valid is ignored outside IDLE; operands must not be re-sampled while busy.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: i_a signed, i_b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Signed operands are converted to magnitude at accept, and the result sign is restored in FIX.
- Multiply:
  - Shift-add into a 2*BIT_W product register, one multiplier bit per cycle, LSB first.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word of the signed-corrected 2*BIT_W product.
- Divide:
  - Restoring division, one quotient bit per cycle, MSB first; BIT_W+1-bit remainder register.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); truncation toward zero.
- Special cases, resolved in FIX while still using the full latency:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → i_a.
  - Signed overflow (i_a = 1<<(BIT_W-1), i_b = all ones): DIV → i_a; REM → 0.
- Width rules: all datapath arithmetic is unsigned on BIT_W+1 bits. Negation is two's complement modulo 2^BIT_W (2^(2*BIT_W) for products).
- o_result changes only in DONE and at reset.

Decomposition:
- Shared package holds:
  - funct3 localparams MUL..REMU.
  - State encoding: IDLE, CALC, FIX, DONE (2-bit).
  - A helper constant for the iteration count derived from BIT_W.
- The same package also holds the EX-stage mux select codes that route o_result versus the ALU output.
- No sub-module: the shift-add and restoring-divide datapaths share the product/remainder register and counter, so the block stays flat.

Test Plan:
- Reset then MUL: i_a=7, i_b=0xFFFFFFFD → o_result 0xFFFFFFEB; o_done 34 edges after accept, high for exactly one cycle; o_ready low throughout.
- High-word multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Divide-by-zero and overflow, each with unchanged latency:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Handshake:
  - Hold i_valid high with changing operands during CALC → no extra accept, and the result matches the first operands.
  - Second op accepted in the first IDLE cycle after DONE → correct second result.
- Reset mid-operation: drop rst_n at CALC iteration 10 → o_ready=1, o_done=0, o_result=0 immediately. No o_done appears afterwards, and the next MUL 3×4 → 12.
